hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- RW, $clog2(NREG), register index width.
- ALU_LAT, 1, cycles from issue until an ALU result is readable.
- LOAD_LAT, 2, cycles from issue until a load result is readable.
- CW, 3, per-register countdown width; ALU_LAT and LOAD_LAT SHALL each be at most 2^CW-1.
- FWD_SLACK, 1, largest countdown value still covered by forwarding; 0 means no forwarding.
- FLUSH_CYC, 1, number of cycles flush stays high per redirect, minimum 1.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, the single clock.
- rst, in, 1, asynchronous active-high reset.
- id_valid, in, 1, an instruction is present in ID.
- id_rs, in, RW, first source register.
- id_rt, in, RW, second source register.
- id_rs_used, in, 1, id_rs is actually read.
- id_rt_used, in, 1, id_rt is actually read.
- id_rd, in, RW, destination register.
- id_regwen, in, 1, the instruction writes id_rd.
- id_memread, in, 1, the instruction is a load.
- ex_redirect, in, 1, taken branch or jump resolved this cycle.
- stall, out, 1, hold PC and IF/ID, and insert a bubble.
- flush, out, 1, squash IF and ID.
- issue, out, 1, the ID instruction advances this cycle.
- busy, out, NREG, per-register pending-write flags.
- stall_count, out, 16, saturating count of stall cycles.

Function
REQ-003 Each register r from 1 to NREG-1 SHALL hold a CW-bit countdown cnt[r]; cnt[0] SHALL be constant 0.
REQ-004 Every cycle, each nonzero cnt[r] SHALL decrement by 1 unless REQ-007 loads it.
REQ-005 stall SHALL be combinational and high exactly when all of the following hold:
- id_valid is high and flush is low;
- for either source: the source is used, the source is not register 0, and its cnt exceeds FWD_SLACK.
REQ-006 issue SHALL equal id_valid AND NOT stall AND NOT flush.
REQ-007 On issue with id_regwen=1 and id_rd not 0, the next cnt[id_rd] SHALL be the larger of (LOAD_LAT if id_memread else ALU_LAT) and the decremented old value (WAW case).
REQ-008 Issue with id_rd=0 or id_regwen=0 SHALL NOT modify any counter.
REQ-009 The stall decision SHALL use pre-update counter values; a same-cycle issue never affects its own sources.
REQ-010 busy[r] SHALL equal (cnt[r] not 0); busy[0] SHALL be 0.
REQ-011 The flush FSM SHALL have states IDLE and FLUSHING, with a counter fcnt:
- IDLE to FLUSHING on ex_redirect when FLUSH_CYC > 1, loading fcnt = FLUSH_CYC-1;
- FLUSHING decrements fcnt and returns to IDLE when fcnt reaches 1;
- ex_redirect while FLUSHING SHALL reload fcnt = FLUSH_CYC-1.
REQ-012 flush SHALL equal ex_redirect OR (state is FLUSHING); the first flush cycle is therefore zero-latency from ex_redirect.
REQ-013 A flushed ID instruction SHALL NOT issue and SHALL NOT load any counter; flush SHALL have priority over stall.
REQ-014 stall_count SHALL increment on each cycle with stall=1 and SHALL saturate at 16'hFFFF.
REQ-015 With all inputs held low, all counters SHALL reach 0 within 2^CW-1 cycles.

Reset
REQ-016 While rst is high, asynchronously: all cnt = 0, FSM = IDLE, fcnt = 0, stall_count = 0.
REQ-017 During and after reset: busy = 0, and stall = 0 and flush = 0 unless the inputs alone assert them.
REQ-018 Reset asserted mid-flush or mid-countdown SHALL discard all state with no residual stall.

Structure
REQ-019 A shared package hazard_pkg SHALL hold:
- the default latency constants;
- the flush FSM state enum;
- a function computing the larger of two CW-bit values.
REQ-020 Sub-module sb_entry (one countdown, load/decrement logic, busy flag) SHALL be instantiated NREG-1 times; all stall and FSM logic SHALL remain in the top.

Verification
REQ-021 Load to r5, then a consumer of rs=5 in the next cycle, FWD_SLACK=1 -> stall=1 for 1 cycle, then issue=1; stall_count=1.
REQ-022 ALU write to r7, then a consumer of rt=7 next cycle -> stall=0 with FWD_SLACK=1; stall=1 for 1 cycle with FWD_SLACK=0.
REQ-023 Consumer reads r0, or id_rs_used=0 on a busy register -> stall=0.
REQ-024 FLUSH_CYC=3, ex_redirect pulsed, re-pulsed 1 cycle later -> flush high 4 consecutive cycles, no counter loads during them.
REQ-025 Load to r3 (cnt=2) and ALU write to r3 next cycle -> cnt[3]=1 (max of 1 and 1), busy[3] clears 1 cycle later.
REQ-026 rst asserted while cnt[9]=2 and FSM=FLUSHING -> busy=0, flush=0 immediately; stall_count=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants, flush FSM state type and the countdown max helper
// used by the hazard scoreboard and its per-register entries.
package hazard_pkg;

  localparam int ALU_LAT_DEF  = 1;
  localparam int LOAD_LAT_DEF = 2;
  localparam int CW_DEF       = 3;
  localparam int CW_MAX       = 8;

  typedef enum logic {
    FL_IDLE,
    FL_FLUSHING
  } flush_state_e;

  // Callers zero-extend their CW-bit operands to CW_MAX and truncate the result.
  function automatic logic [CW_MAX-1:0] max_cw(input logic [CW_MAX-1:0] a,
                                                input logic [CW_MAX-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's pending-write countdown: it counts down to zero on its own,
// and on a load it takes the larger of the new latency and the decremented value.
module sb_entry
  import hazard_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_lat,
  output logic [CW-1:0] o_cnt,
  output logic          o_busy
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_dec;

  assign w_dec = (r_cnt != '0) ? r_cnt - CW'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= CW'(max_cw(CW_MAX'(i_lat), CW_MAX'(w_dec)));
    else
      r_cnt <= w_dec;
  end

  assign o_cnt  = r_cnt;
  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard for an in-order pipeline: stalls ID on an unforwardable
// RAW hazard, squashes IF/ID on a redirect, and counts stall cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG      = 32,
  parameter int RW        = $clog2(NREG),
  parameter int ALU_LAT   = ALU_LAT_DEF,
  parameter int LOAD_LAT  = LOAD_LAT_DEF,
  parameter int CW        = CW_DEF,
  parameter int FWD_SLACK = 1,
  parameter int FLUSH_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_regwen,
  input  logic            id_memread,
  input  logic            ex_redirect,
  output logic            stall,
  output logic            flush,
  output logic            issue,
  output logic [NREG-1:0] busy,
  output logic [15:0]     stall_count
);

  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [FW-1:0] FRELOAD = FW'(FLUSH_CYC - 1);

  logic [CW-1:0] w_cnt [NREG];
  logic [CW-1:0] w_lat;
  logic          w_rs_haz;
  logic          w_rt_haz;

  flush_state_e  r_state;
  flush_state_e  w_state_nxt;
  logic [FW-1:0] r_fcnt;
  logic [FW-1:0] w_fcnt_nxt;
  logic [15:0]   r_stall_count;

  assign w_lat = id_memread ? CW'(LOAD_LAT) : CW'(ALU_LAT);

  assign w_cnt[0] = '0;
  assign busy[0]  = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_entry
    sb_entry #(.CW(CW)) u_entry (
      .clk    (clk),
      .rst    (rst),
      .i_load (issue & id_regwen & (id_rd == RW'(g))),
      .i_lat  (w_lat),
      .o_cnt  (w_cnt[g]),
      .o_busy (busy[g])
    );
  end

  // Counters are read before this cycle's load, so an instruction never waits on itself.
  assign w_rs_haz = id_rs_used && (id_rs != '0) && (32'(w_cnt[id_rs]) > 32'(FWD_SLACK));
  assign w_rt_haz = id_rt_used && (id_rt != '0) && (32'(w_cnt[id_rt]) > 32'(FWD_SLACK));

  assign flush = ex_redirect | (r_state == FL_FLUSHING);
  assign stall = id_valid & ~flush & (w_rs_haz | w_rt_haz);
  assign issue = id_valid & ~stall & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      FL_IDLE: begin
        if (ex_redirect && (FLUSH_CYC > 1)) begin
          w_state_nxt = FL_FLUSHING;
          w_fcnt_nxt  = FRELOAD;
        end
      end
      FL_FLUSHING: begin
        if (ex_redirect) begin
          w_fcnt_nxt = FRELOAD;
        end else if (r_fcnt <= FW'(1)) begin
          w_state_nxt = FL_IDLE;
          w_fcnt_nxt  = '0;
        end else begin
          w_fcnt_nxt = r_fcnt - FW'(1);
        end
      end
      default: begin
        w_state_nxt = FL_IDLE;
        w_fcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FL_IDLE;
      r_fcnt        <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      if (stall && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed per-cycle vectors push expected outputs
// into a queue; a negedge monitor pops and compares against the selected instance.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_rs_used = 1'b0;
  logic        id_rt_used = 1'b0;
  logic [4:0]  id_rd = '0;
  logic        id_regwen = 1'b0;
  logic        id_memread = 1'b0;
  logic        ex_redirect = 1'b0;

  logic        stall_a, flush_a, issue_a;
  logic [31:0] busy_a;
  logic [15:0] sc_a;
  logic        stall_b, flush_b, issue_b;
  logic [31:0] busy_b;
  logic [15:0] sc_b;

  typedef struct {
    int          idx;
    logic        sel;
    logic        exp_stall;
    logic        exp_flush;
    logic        exp_issue;
    logic [31:0] exp_busy;
    logic [15:0] exp_sc;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_vec   = 0;

  always #5 clk = ~clk;

  // Instance A: forwarding covers countdown 1, three-cycle flush.
  hazard_scoreboard #(.FWD_SLACK(1), .FLUSH_CYC(3)) u_dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwen(id_regwen), .id_memread(id_memread), .ex_redirect(ex_redirect),
    .stall(stall_a), .flush(flush_a), .issue(issue_a), .busy(busy_a),
    .stall_count(sc_a)
  );

  // Instance B: no forwarding, single-cycle flush.
  hazard_scoreboard #(.FWD_SLACK(0), .FLUSH_CYC(1)) u_dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwen(id_regwen), .id_memread(id_memread), .ex_redirect(ex_redirect),
    .stall(stall_b), .flush(flush_b), .issue(issue_b), .busy(busy_b),
    .stall_count(sc_b)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic rsu, input logic rtu, input logic [4:0] rd,
                      input logic wen, input logic mem, input logic redir,
                      input logic r, input logic sel,
                      input logic e_st, input logic e_fl, input logic e_is,
                      input logic [31:0] e_busy, input logic [15:0] e_sc);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_rd = rd; id_regwen = wen; id_memread = mem; ex_redirect = redir; rst = r;
    e.idx = n_vec; e.sel = sel; e.exp_stall = e_st; e.exp_flush = e_fl;
    e.exp_issue = e_is; e.exp_busy = e_busy; e.exp_sc = e_sc;
    q.push_back(e);
    n_vec++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel) begin
          chk("stall_b", e.idx, 32'(stall_b), 32'(e.exp_stall));
          chk("flush_b", e.idx, 32'(flush_b), 32'(e.exp_flush));
          chk("issue_b", e.idx, 32'(issue_b), 32'(e.exp_issue));
          chk("busy_b",  e.idx, busy_b,       e.exp_busy);
          chk("count_b", e.idx, 32'(sc_b),    32'(e.exp_sc));
        end else begin
          chk("stall_a", e.idx, 32'(stall_a), 32'(e.exp_stall));
          chk("flush_a", e.idx, 32'(flush_a), 32'(e.exp_flush));
          chk("issue_a", e.idx, 32'(issue_a), 32'(e.exp_issue));
          chk("busy_a",  e.idx, busy_a,       e.exp_busy);
          chk("count_a", e.idx, 32'(sc_a),    32'(e.exp_sc));
        end
      end
    end
  end

  initial begin : stimulus
    //    v rs rt su tu rd w m rd rst sel  st fl is busy      sc
    // reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 32'h0,   0);
    // load r5, dependent consumer: one stall cycle then issue
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,  0, 0, 1, 32'h0,   0);
    step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 32'h20,  0);
    step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h20,  1);
    // ALU write r7, consumer on rt forwarded
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  0, 0, 1, 32'h0,   1);
    step(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h80,  1);
    // load r9; unused busy source and r0 source never stall
    step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0,  0, 0, 1, 32'h0,   1);
    step(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h200, 1);
    step(1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h200, 1);
    // WAW on r3: load then ALU, busy clears one cycle after the ALU write
    step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0,  0, 0, 1, 32'h0,   1);
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,  0, 0, 1, 32'h8,   1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h8,   1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,   1);
    // redirect, re-redirect: four flush cycles, flushed loads never land
    step(1, 0, 0, 0, 0, 6, 1, 1, 1, 0, 0,  0, 1, 0, 32'h0,   1);
    step(1, 0, 0, 0, 0, 6, 1, 1, 1, 0, 0,  0, 1, 0, 32'h0,   1);
    step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0,  0, 1, 0, 32'h0,   1);
    step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0,  0, 1, 0, 32'h0,   1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,   1);
    // flush beats stall, then reset mid-countdown and mid-flush
    step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0,  0, 0, 1, 32'h0,   1);
    step(1, 9, 0, 1, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 32'h200, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 32'h0,   0);
    step(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h0,   0);
    // instance B: no forwarding
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 32'h0,   0);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1,  0, 0, 1, 32'h0,   0);
    step(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 32'h80,  0);
    step(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 1, 32'h0,   1);
    step(1, 0, 7, 0, 1, 0, 0, 0, 1, 0, 1,  0, 1, 0, 32'h0,   1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 32'h0,   1);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 0, 1, 32'h0,   1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 32'h0,   1);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
